// File: rtl/slc_datapath_p_if.sv
// Memory handshake bundle between the LC-3 style datapath and its memory.
// The datapath owns the request side (master); the memory model or
// controller attaches through the slave modport.
interface slc_datapath_p_if #(
  parameter int W = 16
);
  logic         mem_rd_start;
  logic         mem_wr_start;
  logic         mem_ack;
  logic [W-1:0] mem_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_busy;
  logic         mem_done;
  logic         mem_err;

  modport master (
    input  mem_rd_start, mem_wr_start, mem_ack, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_busy, mem_done, mem_err
  );

  modport slave (
    output mem_rd_start, mem_wr_start, mem_ack, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_busy, mem_done, mem_err
  );
endinterface

// File: rtl/slc_datapath_p.sv
// LC-3 style datapath: gated bus, 8-entry register file, ALU, address adder,
// PC/MAR/MDR/IR/LED/CC/BEN registers and a read/write memory FSM with an
// ack timeout.
module slc_datapath_p #(
  parameter int W      = 16,
  parameter int LEDW   = 10,
  parameter int MEM_TO = 15
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
  input  logic            GatePC, GateMDR, GateALU, GateMARMUX,
  input  logic            SR2MUX, ADDR1MUX, DRMUX, SR1MUX,
  input  logic [1:0]      PCMUX, ADDR2MUX,
  input  logic [2:0]      ALUK,
  slc_datapath_p_if.master mem,
  output logic [W-1:0]    MAR, MDR, PC, IR,
  output logic [LEDW-1:0] LED,
  output logic [2:0]      CC,
  output logic            BEN,
  output logic            bus_err
);

  localparam int         SHW     = $clog2(W);
  localparam logic [7:0] TO_LAST = 8'(MEM_TO - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} mem_state_e;

  logic [W-1:0]    pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [LEDW-1:0] led_q, led_d;
  logic [2:0]      cc_q, cc_d;
  logic            ben_q, ben_d;
  logic [W-1:0]    rf_q [8];
  logic [W-1:0]    rf_d [8];

  mem_state_e      state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            done_q, done_d, err_q, err_d;
  logic [W-1:0]    addr_q, addr_d;
  logic            rd_capture, busy;

  logic [W-1:0]    bus, alu_res, alu_b, sr1_val, sr2_val;
  logic [W-1:0]    addr1, addr2, addr_sum, pc_mux;
  logic [W-1:0]    imm5, off6, off9, off11;
  logic [2:0]      dr_idx, sr1_idx;
  logic [3:0]      gates;

  assign imm5  = {{(W-5){ir_q[4]}},  ir_q[4:0]};
  assign off6  = {{(W-6){ir_q[5]}},  ir_q[5:0]};
  assign off9  = {{(W-9){ir_q[8]}},  ir_q[8:0]};
  assign off11 = {{(W-11){ir_q[10]}}, ir_q[10:0]};

  assign dr_idx  = DRMUX  ? 3'd7 : ir_q[11:9];
  assign sr1_idx = SR1MUX ? ir_q[8:6] : ir_q[11:9];
  assign sr1_val = rf_q[sr1_idx];
  assign sr2_val = rf_q[ir_q[2:0]];
  assign alu_b   = SR2MUX ? sr2_val : imm5;

  assign addr1    = ADDR1MUX ? sr1_val : pc_q;
  assign addr_sum = addr1 + addr2;

  assign gates   = {GatePC, GateMDR, GateALU, GateMARMUX};
  assign bus_err = ($countones(gates) > 1);

  // Bus driver: exactly one gate drives, anything else floats to zero.
  always_comb begin
    // NOTE: default assignment first so every path assigns bus and no latch is inferred.
    bus = '0;
    case (gates)
      4'b1000: bus = pc_q;
      4'b0100: bus = mdr_q;
      4'b0010: bus = alu_res;
      4'b0001: bus = addr_sum;
      default: bus = '0;
    endcase
  end

  // ALU: operation picked by ALUK, shifts use the low log2(W) bits of B.
  always_comb begin
    case (ALUK)
      3'd0:    alu_res = sr1_val + alu_b;
      3'd1:    alu_res = sr1_val & alu_b;
      3'd2:    alu_res = ~sr1_val;
      3'd3:    alu_res = sr1_val;
      3'd4:    alu_res = sr1_val ^ alu_b;
      3'd5:    alu_res = sr1_val << alu_b[SHW-1:0];
      3'd6:    alu_res = $signed(sr1_val) >>> alu_b[SHW-1:0];
      default: alu_res = sr1_val - alu_b;
    endcase
  end

  // Address offset and next-PC selection.
  always_comb begin
    case (ADDR2MUX)
      2'd0:    addr2 = '0;
      2'd1:    addr2 = off6;
      2'd2:    addr2 = off9;
      default: addr2 = off11;
    endcase
    case (PCMUX)
      2'd0:    pc_mux = pc_q + W'(1);
      2'd1:    pc_mux = addr_sum;
      2'd2:    pc_mux = bus;
      default: pc_mux = pc_q;
    endcase
  end

  // Architectural register next values.
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    led_d = led_q;
    cc_d  = cc_q;
    ben_d = ben_q;
    rf_d  = rf_q;
    if (LD_PC)  pc_d  = pc_mux;
    if (LD_IR)  ir_d  = bus;
    if (LD_MAR) mar_d = bus;
    // The bus may not overwrite MDR while a memory cycle owns it.
    if (rd_capture)           mdr_d = mem.mem_rdata;
    else if (LD_MDR && !busy) mdr_d = bus;
    if (LD_LED) led_d = ir_q[LEDW-1:0];
    if (LD_CC)  cc_d  = bus[W-1] ? 3'b100 : ((bus == '0) ? 3'b010 : 3'b001);
    if (LD_BEN) ben_d = (ir_q[11] & cc_q[2]) | (ir_q[10] & cc_q[1]) | (ir_q[9] & cc_q[0]);
    if (LD_REG) rf_d[dr_idx] = bus;
  end

  // Architectural registers and register file.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      led_q <= '0;
      cc_q  <= '0;
      ben_q <= 1'b0;
      // NOTE: the register file is reset because software relies on every Rn reading zero after reset.
      rf_q  <= '{default: '0};
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      led_q <= led_d;
      cc_q  <= cc_d;
      ben_q <= ben_d;
      rf_q  <= rf_d;
    end
  end

  // Memory FSM state register, timeout counter, completion flags, latched address.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
    end
  end

  // Memory FSM next state: read beats write, ack beats timeout, IDLE ignores ack.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    addr_d     = addr_q;
    rd_capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (mem.mem_rd_start) begin
          state_d = S_RD;
          addr_d  = mar_q;
        end else if (mem.mem_wr_start) begin
          state_d = S_WR;
          addr_d  = mar_q;
        end
      end
      S_RD, S_WR: begin
        if (mem.mem_ack) begin
          state_d    = S_IDLE;
          done_d     = 1'b1;
          rd_capture = (state_q == S_RD);
        end else if (cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory FSM outputs decoded from the current state.
  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    busy        = 1'b0;
    case (state_q)
      S_RD: begin
        mem.mem_req = 1'b1;
        busy        = 1'b1;
      end
      S_WR: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        busy        = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem.mem_busy  = busy;
  assign mem.mem_done  = done_q;
  assign mem.mem_err   = err_q;
  assign mem.mem_addr  = busy ? addr_q : mar_q;
  assign mem.mem_wdata = mdr_q;

  assign PC  = pc_q;
  assign IR  = ir_q;
  assign MAR = mar_q;
  assign MDR = mdr_q;
  assign LED = led_q;
  assign CC  = cc_q;
  assign BEN = ben_q;

endmodule

// File: tb/tb_slc_datapath_p.sv
// Directed bench for slc_datapath_p: a W=16 instance carries most vectors,
// a W=32 instance sharing the same control lines covers the wide shift.
module tb_slc_datapath_p;

  logic Clk = 1'b0;
  logic Reset_n;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic SR2MUX, ADDR1MUX, DRMUX, SR1MUX;
  logic [1:0] PCMUX, ADDR2MUX;
  logic [2:0] ALUK;

  slc_datapath_p_if #(.W(16)) mif ();
  slc_datapath_p_if #(.W(32)) mif32 ();

  logic [15:0] mar, mdr, pc, ir;
  logic [9:0]  led;
  logic [2:0]  cc;
  logic        ben, bus_err;
  logic [31:0] mar32, mdr32, pc32, ir32;
  logic [9:0]  led32;
  logic [2:0]  cc32;
  logic        ben32, bus_err32;

  int n_tests = 0;
  int n_fail  = 0;

  slc_datapath_p #(.W(16), .LEDW(10), .MEM_TO(15)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .mem(mif),
    .MAR(mar), .MDR(mdr), .PC(pc), .IR(ir), .LED(led), .CC(cc), .BEN(ben),
    .bus_err(bus_err)
  );

  slc_datapath_p #(.W(32), .LEDW(10), .MEM_TO(15)) u_dut32 (
    .Clk(Clk), .Reset_n(Reset_n),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .mem(mif32),
    .MAR(mar32), .MDR(mdr32), .PC(pc32), .IR(ir32), .LED(led32), .CC(cc32), .BEN(ben32),
    .bus_err(bus_err32)
  );

  always #5 Clk = ~Clk;

  // ALU vectors with R1=0xFFFF, imm5=-1, R7=0 (IR=0x127F).
  logic [2:0]  alu_op_v  [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd4};
  logic        alu_sr2_v [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] alu_exp_v [10] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000,
                                  16'h8000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF};
  // Address adder vectors with PC=1, R1=0xFFFF, IR=0x127F.
  logic        adr1_v    [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0]  adr2_v    [6]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
  logic [15:0] adr_exp_v [6]  = '{16'h0001, 16'h0000, 16'h0080, 16'h0280, 16'hFFFF, 16'h007E};

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_ctrl();
    {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = '0;
    {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
    {SR2MUX, ADDR1MUX, DRMUX, SR1MUX} = '0;
    PCMUX = 2'd0;
    ADDR2MUX = 2'd0;
    ALUK = 3'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Single read with an immediate ack, including the done cycle.
  task automatic mem_read(input bit wide, input logic [31:0] d);
    if (wide) mif32.mem_rd_start = 1'b1;
    else      mif.mem_rd_start   = 1'b1;
    tick();
    mif.mem_rd_start   = 1'b0;
    mif32.mem_rd_start = 1'b0;
    if (wide) begin
      mif32.mem_ack   = 1'b1;
      mif32.mem_rdata = d;
    end else begin
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = d[15:0];
    end
    tick();
    mif.mem_ack   = 1'b0;
    mif32.mem_ack = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int req_cnt, done_cnt, err_cnt, both_cnt, done_at;

    Reset_n = 1'b0;
    clear_ctrl();
    mif.mem_rd_start = 1'b0;   mif.mem_wr_start = 1'b0;
    mif.mem_ack = 1'b0;        mif.mem_rdata = '0;
    mif32.mem_rd_start = 1'b0; mif32.mem_wr_start = 1'b0;
    mif32.mem_ack = 1'b0;      mif32.mem_rdata = '0;
    tick();
    tick();

    // Reset state
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_mar", mar, 0);
    check("rst_mdr", mdr, 0);
    check("rst_led", led, 0);
    check("rst_cc", cc, 0);
    check("rst_ben", ben, 0);
    check("rst_req", mif.mem_req, 0);
    check("rst_we", mif.mem_we, 0);
    check("rst_done", mif.mem_done, 0);
    check("rst_err", mif.mem_err, 0);
    check("rst_busy", mif.mem_busy, 0);
    Reset_n = 1'b1;
    tick();

    // Fetch step: MAR <- PC, PC <- PC+1
    GatePC = 1; LD_MAR = 1; PCMUX = 2'd0; LD_PC = 1;
    tick();
    clear_ctrl();
    check("fetch_mar", mar, 16'h0000);
    check("fetch_pc", pc, 16'h0001);

    // Bring 0x0040 into MAR through MDR
    mem_read(1'b0, 32'h0040);
    check("boot_mdr", mdr, 16'h0040);
    GateMDR = 1; LD_MAR = 1;
    tick();
    clear_ctrl();
    check("boot_mar", mar, 16'h0040);

    // Read with ack in the fourth request cycle
    mif.mem_rd_start = 1'b1;
    tick();
    mif.mem_rd_start = 1'b0;
    req_cnt = 0; done_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      mif.mem_ack   = (i == 3);
      mif.mem_rdata = (i == 3) ? 16'hBEEF : 16'h0000;
      if (i == 0) begin
        check("rd_addr", mif.mem_addr, 16'h0040);
        check("rd_we", mif.mem_we, 0);
      end
      req_cnt  += int'(mif.mem_req);
      done_cnt += int'(mif.mem_done);
      err_cnt  += int'(mif.mem_err);
      tick();
    end
    mif.mem_ack = 1'b0;
    check("rd_req_cycles", req_cnt, 4);
    check("rd_done_pulses", done_cnt, 1);
    check("rd_err_pulses", err_cnt, 0);
    check("rd_mdr", mdr, 16'hBEEF);

    // Write with no ack: timeout, plus MAR/MDR loads and a start while busy
    mif.mem_wr_start = 1'b1;
    tick();
    mif.mem_wr_start = 1'b0;
    req_cnt = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0; done_at = -1;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin
        check("wr_we", mif.mem_we, 1);
        check("wr_addr", mif.mem_addr, 16'h0040);
        check("wr_wdata", mif.mem_wdata, 16'hBEEF);
      end
      if (i == 2) begin
        GatePC = 1; LD_MAR = 1; LD_MDR = 1;
      end
      if (i == 3) clear_ctrl();
      mif.mem_rd_start = (i == 4);
      if (i == 6) begin
        check("wr_busy_start_ignored", mif.mem_we, 1);
        check("wr_addr_held", mif.mem_addr, 16'h0040);
        check("wr_mar_updated", mar, 16'h0001);
      end
      req_cnt  += int'(mif.mem_req);
      done_cnt += int'(mif.mem_done);
      err_cnt  += int'(mif.mem_err);
      both_cnt += int'(mif.mem_done && mif.mem_err);
      if (mif.mem_done && done_at < 0) done_at = i;
      tick();
    end
    check("to_req_cycles", req_cnt, 15);
    check("to_done_pulses", done_cnt, 1);
    check("to_err_pulses", err_cnt, 1);
    check("to_done_err_together", both_cnt, 1);
    check("to_done_cycle", done_at, 15);
    check("to_mdr_kept", mdr, 16'hBEEF);

    // Ack while idle is ignored
    mif.mem_ack = 1'b1; mif.mem_rdata = 16'h1234;
    tick();
    check("idle_ack_done", mif.mem_done, 0);
    mif.mem_ack = 1'b0;
    tick();
    check("idle_ack_mdr", mdr, 16'hBEEF);
    check("idle_ack_busy", mif.mem_busy, 0);

    // Both starts together: read wins
    mif.mem_rd_start = 1'b1; mif.mem_wr_start = 1'b1;
    tick();
    mif.mem_rd_start = 1'b0; mif.mem_wr_start = 1'b0;
    check("both_busy", mif.mem_busy, 1);
    check("both_we", mif.mem_we, 0);
    mif.mem_ack = 1'b1; mif.mem_rdata = 16'h127F;
    tick();
    mif.mem_ack = 1'b0;
    tick();
    check("both_mdr", mdr, 16'h127F);

    // IR <- MDR, then LED <- IR[9:0]
    GateMDR = 1; LD_IR = 1;
    tick();
    clear_ctrl();
    check("ir_load", ir, 16'h127F);
    LD_LED = 1;
    tick();
    clear_ctrl();
    check("led_load", led, 10'h27F);

    // ADD R1,R1,#-1 with R1=0
    SR1MUX = 1; SR2MUX = 0; ALUK = 3'd0; GateALU = 1; LD_REG = 1; LD_CC = 1; LD_MAR = 1;
    tick();
    clear_ctrl();
    check("add_bus", mar, 16'hFFFF);
    check("add_cc", cc, 3'b100);

    // ALU operation table
    for (int k = 0; k < 10; k++) begin
      SR1MUX = 1; SR2MUX = alu_sr2_v[k]; ALUK = alu_op_v[k]; GateALU = 1; LD_MAR = 1;
      tick();
      clear_ctrl();
      check($sformatf("alu_op%0d_sr2%0d", alu_op_v[k], alu_sr2_v[k]), mar, alu_exp_v[k]);
    end

    // CC zero, then BEN sampling the old CC in the same cycle as LD_CC
    SR1MUX = 1; ALUK = 3'd2; GateALU = 1; LD_CC = 1;
    tick();
    clear_ctrl();
    check("cc_zero", cc, 3'b010);
    GatePC = 1; LD_CC = 1; LD_BEN = 1;
    tick();
    clear_ctrl();
    check("cc_pos", cc, 3'b001);
    check("ben_old_cc", ben, 0);
    LD_BEN = 1;
    tick();
    clear_ctrl();
    check("ben_p", ben, 1);

    // Address adder through MARMUX
    for (int k = 0; k < 6; k++) begin
      SR1MUX = 1; ADDR1MUX = adr1_v[k]; ADDR2MUX = adr2_v[k]; GateMARMUX = 1; LD_MAR = 1;
      tick();
      clear_ctrl();
      check($sformatf("marmux_a1_%0d_a2_%0d", adr1_v[k], adr2_v[k]), mar, adr_exp_v[k]);
    end

    // PCMUX selections
    PCMUX = 2'd1; ADDR1MUX = 0; ADDR2MUX = 2'd2; LD_PC = 1;
    tick();
    clear_ctrl();
    check("pcmux_adder", pc, 16'h0080);
    PCMUX = 2'd3; LD_PC = 1;
    tick();
    clear_ctrl();
    check("pcmux_hold", pc, 16'h0080);
    PCMUX = 2'd2; GateMDR = 1; LD_PC = 1;
    tick();
    clear_ctrl();
    check("pcmux_bus", pc, 16'h127F);
    PCMUX = 2'd0; LD_PC = 1;
    tick();
    clear_ctrl();
    check("pcmux_inc", pc, 16'h1280);

    // DRMUX=1 writes R7, then read back via SR2: R1 + R7
    GatePC = 1; DRMUX = 1; LD_REG = 1;
    tick();
    clear_ctrl();
    SR1MUX = 1; SR2MUX = 1; ALUK = 3'd0; GateALU = 1; LD_MAR = 1;
    tick();
    clear_ctrl();
    check("r7_add", mar, 16'h127F);

    // Two gates at once: bus forced to zero and flagged
    GatePC = 1; GateMDR = 1; LD_MAR = 1;
    #1;
    check("conflict_flag", bus_err, 1);
    tick();
    clear_ctrl();
    #1;
    check("conflict_bus", mar, 16'h0000);
    check("conflict_clear", bus_err, 0);

    // Reset in the middle of a read, then a late ack
    mif.mem_rd_start = 1'b1;
    tick();
    mif.mem_rd_start = 1'b0;
    check("mid_rd_busy", mif.mem_busy, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_busy", mif.mem_busy, 0);
    check("async_req", mif.mem_req, 0);
    check("async_pc", pc, 0);
    tick();
    Reset_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      mif.mem_ack = 1'b1; mif.mem_rdata = 16'hABCD;
      done_cnt += int'(mif.mem_done);
      tick();
    end
    mif.mem_ack = 1'b0;
    check("rst_abort_done", done_cnt, 0);
    check("rst_abort_mdr", mdr, 16'h0000);
    check("rst_abort_idle", mif.mem_busy, 0);

    // W=32 arithmetic shift right: 0x80000000 >>> 4
    mem_read(1'b1, 32'h0000_0004);
    GateMDR = 1; LD_IR = 1;
    tick();
    clear_ctrl();
    check("w32_ir", ir32, 32'h0000_0004);
    mem_read(1'b1, 32'h8000_0000);
    GateMDR = 1; LD_REG = 1; DRMUX = 0;
    tick();
    clear_ctrl();
    SR1MUX = 0; SR2MUX = 0; ALUK = 3'd6; GateALU = 1; LD_MAR = 1;
    tick();
    clear_ctrl();
    check("w32_sra", mar32, 32'hF800_0000);
    SR1MUX = 0; SR2MUX = 0; ALUK = 3'd5; GateALU = 1; LD_MAR = 1;
    tick();
    clear_ctrl();
    check("w32_shl", mar32, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/slc_datapath_p.md
SLC_DATAPATH_P -- requirements
Module: slc_datapath_p

Interface
REQ-001 SHALL have parameter W, default 16, giving datapath width; legal range 16..32.
REQ-002 SHALL have parameter LEDW, default 10, giving LED register width; legal range 1..W.
REQ-003 SHALL have parameter MEM_TO, default 15, giving the memory-ack timeout in cycles; legal range 1..255.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port list, clock and reset first:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  in  1 each  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus drivers; legal only when one-hot or all-zero.
- SR2MUX, ADDR1MUX, DRMUX, SR1MUX  in  1 each  2:1 selects with LC-3 encoding.
- PCMUX, ADDR2MUX  in  2 each  4:1 selects with LC-3 encoding.
- ALUK  in  3  ALU operation.
- mem_rd_start, mem_wr_start  in  1 each  one-cycle memory-cycle request pulses.
- mem_ack  in  1  memory completion strobe.
- mem_rdata  in  W  read data, valid while mem_ack=1.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  write qualifier for mem_req.
- mem_addr  out  W  equals MAR.
- mem_wdata  out  W  equals MDR.
- mem_busy  out  1  memory FSM not IDLE.
- mem_done  out  1  one-cycle completion pulse.
- mem_err  out  1  one-cycle timeout flag, coincident with mem_done.
- MAR, MDR, PC, IR  out  W each  architectural registers.
- LED  out  LEDW  LED register.
- CC  out  3  condition codes {N,Z,P}.
- BEN  out  1  branch enable.
- bus_err  out  1  combinational flag: more than one Gate input is high.

Function
REQ-006 SHALL drive the bus from the single asserted Gate: PC, MDR, ALU result, or ADDR1+ADDR2 (MARMUX). If no Gate is asserted the bus SHALL be 0. If more than one Gate is asserted the bus SHALL be 0 and bus_err SHALL be 1.
REQ-007 Immediates SHALL be sign-extended to W bits: imm5 from IR[4:0], off6 from IR[5:0], off9 from IR[8:0], off11 from IR[10:0]. Each extension SHALL use its own field MSB.
REQ-008 ADDR2MUX SHALL select, for values 0/1/2/3: 0, off6, off9, off11. ADDR1MUX SHALL select: 0=PC, 1=SR1 value.
REQ-009 PCMUX SHALL select, for values 0/1/2/3: PC+1, ADDR1+ADDR2, bus, hold PC. All sums SHALL be modulo 2^W.
REQ-010 The register file SHALL have 8 registers of W bits each.
- DR: DRMUX=0 selects IR[11:9]; DRMUX=1 selects R7.
- SR1: SR1MUX=0 selects IR[11:9]; SR1MUX=1 selects IR[8:6].
- SR2 is IR[2:0].
- The register file SHALL load from the bus when LD_REG=1.
- Reads SHALL be combinational and SHALL return the old value in the write cycle.
REQ-011 ALU inputs: A = SR1 value; B = imm5 when SR2MUX=0, otherwise SR2 value.
REQ-012 ALUK SHALL select the ALU operation:
- 0: A+B
- 1: A&B
- 2: ~A
- 3: A
- 4: A^B
- 5: A shifted left by B[$clog2(W)-1:0]
- 6: A arithmetic-shifted right by B[$clog2(W)-1:0]
- 7: A-B
REQ-013 CC SHALL load on LD_CC from the bus value: 100 if bus MSB=1; 010 if bus=0; 001 otherwise.
REQ-014 BEN SHALL load on LD_BEN with (IR[11]&N) | (IR[10]&Z) | (IR[9]&P), using the current CC register value.
REQ-015 LED SHALL load IR[LEDW-1:0] on LD_LED. MAR and IR SHALL load from the bus. PC SHALL load the PCMUX output on LD_PC.
REQ-016 The memory FSM SHALL have states IDLE, RD, WR, with these transitions:
- IDLE to RD on mem_rd_start.
- IDLE to WR on mem_wr_start.
- If both starts are asserted together, RD SHALL win and the write SHALL be dropped.
REQ-017 In RD or WR the FSM SHALL:
- assert mem_req=1, with mem_we=1 only in WR;
- hold mem_addr=MAR and mem_wdata=MDR stable for the whole cycle.
REQ-018 On mem_ack in RD, MDR SHALL capture mem_rdata. On mem_ack in RD or WR, mem_done SHALL pulse for one cycle, the FSM SHALL return to IDLE, and mem_req SHALL drop on the next cycle.
REQ-019 A cycle counter SHALL start at 0 on FSM entry and count while mem_ack=0. When it reaches MEM_TO:
- the FSM SHALL abort to IDLE;
- mem_done and mem_err SHALL pulse together for one cycle;
- MDR SHALL remain unchanged.
REQ-020 Starts received while mem_busy=1 SHALL be ignored. mem_ack received in IDLE SHALL be ignored.
REQ-021 LD_MDR from the bus SHALL be ignored while mem_busy=1. In IDLE, LD_MDR SHALL load the bus value.
REQ-022 LD_MAR while mem_busy=1 SHALL update MAR; mem_addr SHALL keep the address latched at FSM entry.

Reset
REQ-023 Reset_n=0 SHALL asynchronously clear all of the following: PC, IR, MAR, MDR, every register-file entry, LED, CC (to 000), BEN, the FSM (to IDLE), and the timeout counter. mem_req, mem_we, mem_done and mem_err SHALL all be 0.
REQ-024 Reset during RD or WR SHALL abort the cycle immediately. No mem_done SHALL be produced for it, and a later mem_ack SHALL be ignored.

Verification
REQ-025 Sequence: GatePC=1, LD_MAR=1, PCMUX=0, LD_PC=1 at PC=0 -> next cycle MAR=0 and PC=1.
REQ-026 Sequence: MAR=0x0040, then mem_rd_start, then mem_ack with mem_rdata=0xBEEF after 3 cycles -> mem_req high for 4 cycles, MDR=0xBEEF, and one mem_done pulse.
REQ-027 Sequence: mem_wr_start with no ack and MEM_TO=15 -> mem_req high for 15 cycles, then mem_done=mem_err=1 for one cycle, with MDR unchanged.
REQ-028 Sequence: IR=0x127F (ADD R1,R1,#-1) with R1=0, ALUK=0, SR2MUX=0, GateALU, LD_REG, LD_CC -> R1=0xFFFF and CC=100.
REQ-029 Sequence: GatePC=GateMDR=1 together -> bus=0 and bus_err=1. Separately, with W=32, ALUK=6, A=0x80000000, B=4 -> result 0xF8000000.
REQ-030 Sequence: Reset_n low during RD, then mem_ack after release -> MDR=0, mem_done stays 0, FSM in IDLE.
